tree_walker: RTL and testbench

- Parametrised successor to the fixed per-tree node ROMs in the TinyML classifier.
- One runtime-loadable node RAM holds N_TREES decision trees.
- A traversal FSM walks each tree in turn for a captured feature vector and returns one class per tree.
- Sits between the feature-extraction front end and the vote/aggregation stage. The valid/ready handshake is on both sides.

---
 rtl/tree_walker_pkg.sv | 47 ++++
 rtl/tree_node_ram.sv | 24 ++
 rtl/tree_walker.sv | 172 +++++++++++++++++
 tb/tb_tree_walker.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tree_walker_pkg.sv
// Shared constants, node-word layout helpers and FSM encoding for the
// decision-tree traversal engine.
package tree_walker_pkg;

    localparam int DEF_ADDR_W     = 10;
    localparam int DEF_N_TREES    = 4;
    localparam int DEF_N_FEAT     = 16;
    localparam int DEF_FEAT_W     = 32;
    localparam int DEF_FEAT_IDX_W = 4;
    localparam int DEF_CLASS_W    = 4;
    localparam int DEF_MAX_DEPTH  = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EVAL = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Node word, MSB..LSB: is_leaf | feat_idx | threshold | left | right | class
    function automatic int node_width(input int addr_w, input int feat_w,
                                      input int feat_idx_w, input int class_w);
        return 1 + feat_idx_w + feat_w + 2 * addr_w + class_w;
    endfunction

    function automatic int off_right(input int class_w);
        return class_w;
    endfunction

    function automatic int off_left(input int addr_w, input int class_w);
        return class_w + addr_w;
    endfunction

    function automatic int off_thr(input int addr_w, input int class_w);
        return class_w + 2 * addr_w;
    endfunction

    function automatic int off_idx(input int addr_w, input int feat_w, input int class_w);
        return class_w + 2 * addr_w + feat_w;
    endfunction

    function automatic int off_leaf(input int addr_w, input int feat_w,
                                    input int feat_idx_w, input int class_w);
        return class_w + 2 * addr_w + feat_w + feat_idx_w;
    endfunction

endpackage

// File: rtl/tree_node_ram.sv
// Single-port node store: synchronous write, registered read-first output.
module tree_node_ram
    import tree_walker_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NODE_W = 61
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [NODE_W-1:0] wdata,
    output logic [NODE_W-1:0] rdata
);

    logic [NODE_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/tree_walker.sv
// Walks N_TREES decision trees from a shared node RAM for one captured
// feature vector and returns one class (plus watchdog flag) per tree.
//
// state | meaning
// IDLE  | ready for a vector; node RAM writable
// READ  | current node address presented to the RAM
// EVAL  | node word valid; pick child or terminate the tree
// DONE  | results held until downstream takes them
module tree_walker
    import tree_walker_pkg::*;
#(
    parameter  int ADDR_W     = DEF_ADDR_W,
    parameter  int N_TREES    = DEF_N_TREES,
    parameter  int N_FEAT     = DEF_N_FEAT,
    parameter  int FEAT_W     = DEF_FEAT_W,
    parameter  int FEAT_IDX_W = DEF_FEAT_IDX_W,
    parameter  int CLASS_W    = DEF_CLASS_W,
    parameter  int MAX_DEPTH  = DEF_MAX_DEPTH,
    localparam int NODE_W     = node_width(ADDR_W, FEAT_W, FEAT_IDX_W, CLASS_W)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_we,
    input  logic [ADDR_W-1:0]            cfg_addr,
    input  logic [NODE_W-1:0]            cfg_wdata,
    output logic                         cfg_ready,
    input  logic [N_TREES*ADDR_W-1:0]    root_addrs,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N_FEAT*FEAT_W-1:0]     in_feats,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N_TREES*CLASS_W-1:0]   out_classes,
    output logic [N_TREES-1:0]           out_err
);

    localparam int TREE_W   = (N_TREES > 1) ? $clog2(N_TREES) : 1;
    localparam int DEPTH_W  = $clog2(MAX_DEPTH + 1);
    localparam int OFF_R    = off_right(CLASS_W);
    localparam int OFF_L    = off_left(ADDR_W, CLASS_W);
    localparam int OFF_THR  = off_thr(ADDR_W, CLASS_W);
    localparam int OFF_IDX  = off_idx(ADDR_W, FEAT_W, CLASS_W);
    localparam int OFF_LEAF = off_leaf(ADDR_W, FEAT_W, FEAT_IDX_W, CLASS_W);
    localparam logic [DEPTH_W-1:0] DEPTH_LAST = DEPTH_W'(MAX_DEPTH - 1);
    localparam logic [TREE_W-1:0]  TREE_LAST  = TREE_W'(N_TREES - 1);

    state_e                      state_q, state_d;
    logic [N_FEAT*FEAT_W-1:0]    feats_q;
    logic [N_TREES*ADDR_W-1:0]   roots_q;
    logic [TREE_W-1:0]           tree_q, tree_nx;
    logic [ADDR_W-1:0]           addr_q, ram_addr, root_nx;
    logic [DEPTH_W-1:0]          depth_q;
    logic [N_TREES*CLASS_W-1:0]  classes_q;
    logic [N_TREES-1:0]          err_q;
    logic [NODE_W-1:0]           node;
    logic                        ram_we, accept;
    logic                        node_leaf, node_term, go_left;
    logic [FEAT_IDX_W-1:0]       node_idx;
    logic signed [FEAT_W-1:0]    node_thr, feat_sel;
    logic [ADDR_W-1:0]           node_left, node_right;
    logic [CLASS_W-1:0]          node_class;
    logic signed [FEAT_W-1:0]    feat_ext [2**FEAT_IDX_W];
    logic [ADDR_W-1:0]           root_arr [N_TREES];

    // Index space beyond N_FEAT reads as zero without a runtime range check.
    for (genvar i = 0; i < 2**FEAT_IDX_W; i++) begin : g_feat
        if (i < N_FEAT) begin : g_real
            assign feat_ext[i] = feats_q[i*FEAT_W +: FEAT_W];
        end else begin : g_zero
            assign feat_ext[i] = '0;
        end
    end

    for (genvar t = 0; t < N_TREES; t++) begin : g_root
        assign root_arr[t] = roots_q[t*ADDR_W +: ADDR_W];
    end

    assign accept     = in_valid && in_ready;
    assign ram_we     = cfg_we && cfg_ready;
    assign ram_addr   = (state_q == ST_IDLE) ? cfg_addr : addr_q;

    assign node_leaf  = node[OFF_LEAF];
    assign node_idx   = node[OFF_IDX +: FEAT_IDX_W];
    assign node_thr   = node[OFF_THR +: FEAT_W];
    assign node_left  = node[OFF_L +: ADDR_W];
    assign node_right = node[OFF_R +: ADDR_W];
    assign node_class = node[0 +: CLASS_W];
    assign feat_sel   = feat_ext[node_idx];
    assign go_left    = (feat_sel <= node_thr);
    assign node_term  = node_leaf || (depth_q == DEPTH_LAST);
    assign tree_nx    = tree_q + TREE_W'(1);
    assign root_nx    = root_arr[tree_nx];

    tree_node_ram #(
        .ADDR_W (ADDR_W),
        .NODE_W (NODE_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (cfg_wdata),
        .rdata (node)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_READ;
            ST_READ: state_d = ST_EVAL;
            ST_EVAL: state_d = (node_term && tree_q == TREE_LAST) ? ST_DONE : ST_READ;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready    = (state_q == ST_IDLE) && !rst;
        cfg_ready   = (state_q == ST_IDLE) && !rst;
        out_valid   = (state_q == ST_DONE) && !rst;
        out_classes = classes_q;
        out_err     = err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            feats_q   <= '0;
            roots_q   <= '0;
            tree_q    <= '0;
            addr_q    <= '0;
            depth_q   <= '0;
            classes_q <= '0;
            err_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        feats_q <= in_feats;
                        roots_q <= root_addrs;
                        tree_q  <= '0;
                        addr_q  <= root_addrs[0 +: ADDR_W];
                        depth_q <= '0;
                    end
                end
                ST_EVAL: begin
                    if (node_term) begin
                        // A watchdog exit reports class 0 with the error flag.
                        classes_q[tree_q*CLASS_W +: CLASS_W] <= node_leaf ? node_class : '0;
                        err_q[tree_q] <= !node_leaf;
                        if (tree_q != TREE_LAST) begin
                            tree_q  <= tree_nx;
                            addr_q  <= root_nx;
                            depth_q <= '0;
                        end
                    end else begin
                        addr_q  <= go_left ? node_left : node_right;
                        depth_q <= depth_q + DEPTH_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tree_walker.sv
// Bench for tree_walker: vector table plus hand-written corner sequences,
// expected results queued at stimulus and compared when out_valid appears.
module tb_tree_walker;

    localparam int ADDR_W     = 10;
    localparam int N_TREES    = 4;
    localparam int N_FEAT     = 16;
    localparam int FEAT_W     = 32;
    localparam int FEAT_IDX_W = 4;
    localparam int CLASS_W    = 4;
    localparam int MAX_DEPTH  = 32;
    localparam int NODE_W     = 1 + FEAT_IDX_W + FEAT_W + 2*ADDR_W + CLASS_W;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        cfg_we;
    logic [ADDR_W-1:0]           cfg_addr;
    logic [NODE_W-1:0]           cfg_wdata;
    logic                        cfg_ready;
    logic [N_TREES*ADDR_W-1:0]   root_addrs;
    logic                        in_valid;
    logic                        in_ready;
    logic [N_FEAT*FEAT_W-1:0]    in_feats;
    logic                        out_valid;
    logic                        out_ready;
    logic [N_TREES*CLASS_W-1:0]  out_classes;
    logic [N_TREES-1:0]          out_err;

    tree_walker #(
        .ADDR_W(ADDR_W), .N_TREES(N_TREES), .N_FEAT(N_FEAT), .FEAT_W(FEAT_W),
        .FEAT_IDX_W(FEAT_IDX_W), .CLASS_W(CLASS_W), .MAX_DEPTH(MAX_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_ready(cfg_ready), .root_addrs(root_addrs),
        .in_valid(in_valid), .in_ready(in_ready), .in_feats(in_feats),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_classes(out_classes), .out_err(out_err)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [N_TREES*CLASS_W-1:0] cls;
        logic [N_TREES-1:0]         err;
        int                         lat;
    } exp_t;

    typedef struct {
        logic [N_TREES*ADDR_W-1:0]  roots;
        int                         fidx;
        logic [FEAT_W-1:0]          fval;
        logic [N_TREES*CLASS_W-1:0] cls;
        logic [N_TREES-1:0]         err;
        int                         lat;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[11];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   acc_edge = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired at edge %0d", name, edge_cnt);
    endtask

    function automatic logic [NODE_W-1:0] mk_node(input logic leaf, input logic [FEAT_IDX_W-1:0] idx,
                                                  input logic [FEAT_W-1:0] thr, input logic [ADDR_W-1:0] l,
                                                  input logic [ADDR_W-1:0] r, input logic [CLASS_W-1:0] c);
        return {leaf, idx, thr, l, r, c};
    endfunction

    function automatic logic [NODE_W-1:0] mk_leaf(input logic [CLASS_W-1:0] c);
        return mk_node(1'b1, '0, '0, '0, '0, c);
    endfunction

    function automatic logic [N_TREES*ADDR_W-1:0] pack_roots(input int r3, input int r2, input int r1, input int r0);
        return {ADDR_W'(r3), ADDR_W'(r2), ADDR_W'(r1), ADDR_W'(r0)};
    endfunction

    function automatic logic [N_FEAT*FEAT_W-1:0] mk_feats(input int fidx, input logic [FEAT_W-1:0] fval);
        logic [N_FEAT*FEAT_W-1:0] v;
        for (int i = 0; i < N_FEAT; i++) v[i*FEAT_W +: FEAT_W] = $urandom;
        v[fidx*FEAT_W +: FEAT_W] = fval;
        return v;
    endfunction

    // Entered and left on a falling edge; node RAM must be writable.
    task automatic write_node(input int a, input logic [NODE_W-1:0] w);
        cfg_we = 1'b1; cfg_addr = ADDR_W'(a); cfg_wdata = w;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic start_inf(input logic [N_TREES*ADDR_W-1:0] roots, input logic [N_FEAT*FEAT_W-1:0] feats,
                             input logic [N_TREES*CLASS_W-1:0] cls, input logic [N_TREES-1:0] err,
                             input int lat, input logic do_wr, input int wr_addr,
                             input logic [NODE_W-1:0] wr_data);
        exp_t e;
        int w = 0;
        while (!in_ready && w < 200) begin @(negedge clk); w++; end
        if (!in_ready) timeout("in_ready_wait");
        root_addrs = roots; in_feats = feats; in_valid = 1'b1;
        cfg_we = do_wr; cfg_addr = ADDR_W'(wr_addr); cfg_wdata = wr_data;
        e.cls = cls; e.err = err; e.lat = lat;
        sb.push_back(e);
        @(negedge clk);
        acc_edge = edge_cnt;
        in_valid = 1'b0; cfg_we = 1'b0;
        in_feats = mk_feats(0, $urandom);
        root_addrs = pack_roots($urandom_range(1023), $urandom_range(1023), $urandom_range(1023), $urandom_range(1023));
        check("in_ready_busy", {63'd0, in_ready}, 64'd0);
        check("cfg_ready_busy", {63'd0, cfg_ready}, 64'd0);
    endtask

    task automatic finish_inf(input int hold);
        exp_t e;
        int w = 0;
        while (!out_valid && w < 500) begin @(negedge clk); w++; end
        if (!out_valid) begin
            timeout("out_valid_wait");
            if (sb.size() > 0) void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            timeout("scoreboard_empty");
        end else begin
            e = sb.pop_front();
            check("latency", 64'(edge_cnt - acc_edge), 64'(e.lat));
            check("out_classes", 64'(out_classes), 64'(e.cls));
            check("out_err", 64'(out_err), 64'(e.err));
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("hold_valid", {63'd0, out_valid}, 64'd1);
                check("hold_classes", 64'(out_classes), 64'(e.cls));
                check("hold_err", 64'(out_err), 64'(e.err));
                check("hold_in_ready", {63'd0, in_ready}, 64'd0);
            end
            out_ready = 1'b1;
            @(negedge clk);
            check("post_done_valid", {63'd0, out_valid}, 64'd0);
            check("post_done_in_ready", {63'd0, in_ready}, 64'd1);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int seen;
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; root_addrs = '0;
        in_valid = 1'b0; in_feats = '0; out_ready = 1'b1;

        vecs[0]  = '{pack_roots(103, 102, 101, 100), 0, 32'd0,         16'h4321, 4'b0000, 8};
        vecs[1]  = '{pack_roots(0, 0, 0, 0),         2, 32'd100,       16'h5555, 4'b0000, 16};
        vecs[2]  = '{pack_roots(0, 0, 0, 0),         2, 32'd101,       16'h6666, 4'b0000, 16};
        vecs[3]  = '{pack_roots(0, 0, 0, 0),         2, 32'hFFFF_FFFB, 16'h5555, 4'b0000, 16};
        vecs[4]  = '{pack_roots(0, 100, 0, 101),     2, 32'd101,       16'h6162, 4'b0000, 12};
        vecs[5]  = '{pack_roots(20, 20, 20, 20),     7, 32'hFFFF_FFF6, 16'h3333, 4'b0000, 16};
        vecs[6]  = '{pack_roots(20, 20, 20, 20),     7, 32'hFFFF_FFF7, 16'h4444, 4'b0000, 16};
        vecs[7]  = '{pack_roots(20, 20, 20, 20),     7, 32'h8000_0000, 16'h3333, 4'b0000, 16};
        vecs[8]  = '{pack_roots(20, 20, 20, 20),     7, 32'h7FFF_FFFF, 16'h4444, 4'b0000, 16};
        vecs[9]  = '{pack_roots(100, 5, 101, 102),   0, 32'd7,         16'h1023, 4'b0100, 2+2+2*MAX_DEPTH+2};
        vecs[10] = '{pack_roots(103, 102, 101, 100), 0, 32'd0,         16'h4321, 4'b0000, 8};

        repeat (3) @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_cfg_ready", {63'd0, cfg_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_in_ready", {63'd0, in_ready}, 64'd1);
        check("rel_cfg_ready", {63'd0, cfg_ready}, 64'd1);
        check("rel_out_valid", {63'd0, out_valid}, 64'd0);
        check("rel_classes", 64'(out_classes), 64'd0);
        check("rel_err", 64'(out_err), 64'd0);

        write_node(100, mk_leaf(4'd1));
        write_node(101, mk_leaf(4'd2));
        write_node(102, mk_leaf(4'd3));
        write_node(103, mk_leaf(4'd4));
        write_node(0,   mk_node(1'b0, 4'd2, 32'd100, 10'd10, 10'd11, 4'd0));
        write_node(10,  mk_leaf(4'd5));
        write_node(11,  mk_leaf(4'd6));
        write_node(20,  mk_node(1'b0, 4'd7, 32'hFFFF_FFF6, 10'd102, 10'd103, 4'd0));
        write_node(5,   mk_node(1'b0, 4'd0, 32'd0, 10'd5, 10'd5, 4'd9));

        for (int i = 0; i < 11; i++) begin
            start_inf(vecs[i].roots, mk_feats(vecs[i].fidx, vecs[i].fval), vecs[i].cls,
                      vecs[i].err, vecs[i].lat, 1'b0, 0, '0);
            finish_inf(0);
        end

        // Write and accept on the same edge: the new leaf must be seen.
        start_inf(pack_roots(104, 104, 104, 104), mk_feats(0, 32'd0), 16'h9999, 4'b0000, 8,
                  1'b1, 104, mk_leaf(4'd9));
        finish_inf(0);

        // Downstream backpressure for 10 cycles, then a new vector straight away.
        out_ready = 1'b0;
        start_inf(vecs[0].roots, mk_feats(0, 32'd0), 16'h4321, 4'b0000, 8, 1'b0, 0, '0);
        finish_inf(10);
        start_inf(vecs[1].roots, mk_feats(2, 32'd100), 16'h5555, 4'b0000, 16, 1'b0, 0, '0);
        finish_inf(0);

        // A node write during traversal is dropped; the same write in IDLE lands.
        start_inf(vecs[1].roots, mk_feats(2, 32'd100), 16'h5555, 4'b0000, 16, 1'b0, 0, '0);
        repeat (2) @(negedge clk);
        check("cfg_ready_traversal", {63'd0, cfg_ready}, 64'd0);
        cfg_we = 1'b1; cfg_addr = 10'd10; cfg_wdata = mk_leaf(4'd7);
        @(negedge clk);
        cfg_we = 1'b0;
        finish_inf(0);
        start_inf(vecs[1].roots, mk_feats(2, 32'd100), 16'h5555, 4'b0000, 16, 1'b0, 0, '0);
        finish_inf(0);
        write_node(10, mk_leaf(4'd7));
        start_inf(vecs[1].roots, mk_feats(2, 32'd100), 16'h7777, 4'b0000, 16, 1'b0, 0, '0);
        finish_inf(0);

        // Reset while tree 1's first node is being evaluated.
        start_inf(vecs[2].roots, mk_feats(2, 32'd101), 16'h6666, 4'b0000, 16, 1'b0, 0, '0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_rel_in_ready", {63'd0, in_ready}, 64'd1);
        check("midrst_classes", 64'(out_classes), 64'd0);
        check("midrst_pending", 64'(sb.size()), 64'd1);
        sb.delete();
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        check("midrst_no_output", 64'(seen), 64'd0);
        start_inf(vecs[2].roots, mk_feats(2, 32'd101), 16'h6666, 4'b0000, 16, 1'b0, 0, '0);
        finish_inf(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
